// File: rtl/rom_stream_fifo.sv
// Paced DEPTH x DATA_W byte-stream FIFO between the ROM fetch front end and the ROM consumer.
// Latency: a write at edge k is readable from edge k+1; dout is registered and valid after the read edge.
// Backpressure: almost_full/almost_empty are advisory and paced; strobes are honoured up to true full/empty.
module rom_stream_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH,
  parameter int AE_LEVEL = 0,
  parameter int PACE     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic                       almost_full,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          din,
  output logic                       almost_empty,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [CW-1:0]     cnt;
  logic              gate;
  logic              is_full;
  logic              is_empty;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_drop;
  logic              rd_miss;

  // Accept/reject decisions; a write into a full FIFO is accepted only when a read frees a slot the same cycle.
  always_comb begin
    is_full  = (cnt == CW'(DEPTH));
    is_empty = (cnt == '0);
    wr_ok    = ~clr & wr_en & (~is_full | rd_en);
    rd_ok    = ~clr & rd_en & ~is_empty;
    wr_drop  = ~clr & wr_en & is_full & ~rd_en;
    rd_miss  = ~clr & rd_en & is_empty;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= din;
  end

  // Registered read data; a read of an empty FIFO returns zero (no fall-through of a same-cycle write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!clr && rd_en) begin
      dout <= is_empty ? '0 : mem[rp];
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_drop) overflow  <= 1'b1;
      if (rd_miss) underflow <= 1'b1;
    end
  end

  generate
    if (PACE > 1) begin : g_pace
      localparam int PW = $clog2(PACE);
      logic [PW-1:0] pc;

      // Free-running pace counter; the gate opens in the last cycle of each period.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc <= '0;
        end else if (clr || pc == PW'(PACE-1)) begin
          pc <= '0;
        end else begin
          pc <= pc + 1'b1;
        end
      end

      assign gate = (pc == PW'(PACE-1));
    end else begin : g_nopace
      assign gate = 1'b1;
    end
  endgenerate

  // Flags depend only on registered state, so there is no input-to-output path.
  assign almost_full  = ~gate | (cnt >= CW'(AF_LEVEL));
  assign almost_empty = ~gate | (cnt <= CW'(AE_LEVEL));
  assign count        = cnt;

endmodule
